// File: rtl/cia_pkg.sv
// -----------------------------------------------------------------------------
// cia -- shared types for the CIA serial-port peer.
//   reg8_t          : 8-bit register/data byte
//   sp_peer_state_t : TX state of the serial-port peer (IDLE / LOW / HIGH)
//   sp_half_clamp() : clamps a requested CNT half-period to a minimum
// -----------------------------------------------------------------------------
package cia;

  typedef logic [7:0] reg8_t;

  typedef enum logic [1:0] {
    SP_IDLE = 2'd0,
    SP_LOW  = 2'd1,
    SP_HIGH = 2'd2
  } sp_peer_state_t;

  // Returns max(hdiv, half_min); both are "half-period minus one" counts.
  function automatic reg8_t sp_half_clamp(input reg8_t hdiv, input reg8_t half_min);
    reg8_t res_s;
    if (hdiv < half_min) begin
      res_s = half_min;
    end else begin
      res_s = hdiv;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/cia_sp_sync.sv
// -----------------------------------------------------------------------------
// cia_sp_sync -- synchroniser and rising-edge detector for the CIA CNT pad.
//   clk   : system clock
//   res_n : asynchronous active-low reset (all flops reset to the idle-high level)
//   din   : asynchronous pad level
//   rise  : registered one-cycle pulse per rising edge of the synchronised level
// Build option: CIA_SP_PEER_FILTER_EN inserts a 3-sample majority filter
// between the synchroniser and the edge detector (+2 cycles latency, rejects
// single-cycle glitches).
// -----------------------------------------------------------------------------
module cia_sp_sync (
  input  logic clk,
  input  logic res_n,
  input  logic din,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic level_s;
  logic prev_r;
  logic rise_r;

  // Two-flop synchroniser for the asynchronous pad level.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

`ifdef CIA_SP_PEER_FILTER_EN
  logic samp1_r;
  logic samp2_r;
  logic filt_r;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Majority vote over the current and two previous synchronised samples.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      samp1_r <= 1'b1;
      samp2_r <= 1'b1;
      filt_r  <= 1'b1;
    end else begin
      samp1_r <= sync_r;
      samp2_r <= samp1_r;
      filt_r  <= maj3(sync_r, samp1_r, samp2_r);
    end
  end

  assign level_s = filt_r;
`else
  assign level_s = sync_r;
`endif

  // Rising-edge detector with a registered pulse output.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      prev_r <= 1'b1;
      rise_r <= 1'b0;
    end else begin
      prev_r <= level_s;
      rise_r <= level_s & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/cia_sp_peer.sv
// -----------------------------------------------------------------------------
// cia_sp_peer -- external peer for the CIA serial port (SP/CNT), MSB first.
// TX drives CNT/SP toward the CIA; RX shifts SP in on rising CNT edges.
//   clk, res_n      : clock, asynchronous active-low reset
//   hdiv            : CNT half-period minus one (clamped to HDIV_MIN-1)
//   tx_valid/ready  : byte handshake, tx_data is the byte
//   abort           : synchronous cancel of TX and RX frames
//   cnt_in, sp_in   : asynchronous pad levels from the CIA
//   cnt_out, sp_out : drive levels, valid while cnt_oe is high
//   rx_valid/rx_data: one-cycle strobe with the received byte (held)
// Build option: CIA_SP_PEER_FILTER_EN enables the CNT glitch filter.
// -----------------------------------------------------------------------------
module cia_sp_peer
  import cia::*;
#(
  parameter int unsigned HDIV_MIN = 2
) (
  input  logic  clk,
  input  logic  res_n,
  input  reg8_t hdiv,
  input  logic  tx_valid,
  input  reg8_t tx_data,
  output logic  tx_ready,
  input  logic  abort,
  input  logic  cnt_in,
  input  logic  sp_in,
  output logic  cnt_out,
  output logic  sp_out,
  output logic  cnt_oe,
  output logic  rx_valid,
  output reg8_t rx_data
);

  localparam reg8_t HALF_MIN = reg8_t'(HDIV_MIN - 32'd1);

  sp_peer_state_t state_r;
  reg8_t          tx_byte_r;
  reg8_t          half_r;
  reg8_t          phase_r;
  logic [2:0]     bit_idx_r;
  logic           cnt_out_r;
  logic           sp_out_r;
  logic           cnt_oe_r;
  logic           tx_ready_r;
  logic           handshake_s;

  logic           cnt_rise_s;
  logic           sp_meta_r;
  logic           sp_sync_r;
  logic           sp_al_s;
  logic [5:0]     oe_hist_r;
  logic           rx_block_s;
  logic [2:0]     rx_cnt_r;
  logic [6:0]     rx_shift_r;
  logic           rx_valid_r;
  reg8_t          rx_data_r;

  assign handshake_s = tx_valid & tx_ready_r & ~abort;

  // TX state machine: one LOW and one HIGH phase per bit, MSB first.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r    <= SP_IDLE;
      tx_byte_r  <= 8'h00;
      half_r     <= 8'h00;
      phase_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      cnt_out_r  <= 1'b1;
      sp_out_r   <= 1'b1;
      cnt_oe_r   <= 1'b0;
      tx_ready_r <= 1'b0;
    end else if (abort) begin
      state_r    <= SP_IDLE;
      phase_r    <= 8'h00;
      cnt_out_r  <= 1'b1;
      sp_out_r   <= 1'b1;
      cnt_oe_r   <= 1'b0;
      tx_ready_r <= 1'b1;
    end else begin
      case (state_r)
        SP_IDLE: begin
          if (handshake_s) begin
            tx_byte_r  <= tx_data;
            half_r     <= sp_half_clamp(hdiv, HALF_MIN);
            phase_r    <= 8'h00;
            bit_idx_r  <= 3'd7;
            sp_out_r   <= tx_data[7];
            cnt_out_r  <= 1'b0;
            cnt_oe_r   <= 1'b1;
            tx_ready_r <= 1'b0;
            state_r    <= SP_LOW;
          end else begin
            tx_ready_r <= 1'b1;
          end
        end
        SP_LOW: begin
          if (phase_r == half_r) begin
            phase_r   <= 8'h00;
            cnt_out_r <= 1'b1;
            state_r   <= SP_HIGH;
          end else begin
            phase_r <= phase_r + 8'd1;
          end
        end
        SP_HIGH: begin
          if (phase_r == half_r) begin
            phase_r <= 8'h00;
            if (bit_idx_r != 3'd0) begin
              bit_idx_r <= bit_idx_r - 3'd1;
              sp_out_r  <= tx_byte_r[bit_idx_r - 3'd1];
              cnt_out_r <= 1'b0;
              state_r   <= SP_LOW;
            end else begin
              cnt_out_r  <= 1'b1;
              sp_out_r   <= 1'b1;
              cnt_oe_r   <= 1'b0;
              tx_ready_r <= 1'b1;
              state_r    <= SP_IDLE;
            end
          end else begin
            phase_r <= phase_r + 8'd1;
          end
        end
        default: begin
          state_r    <= SP_IDLE;
          cnt_out_r  <= 1'b1;
          sp_out_r   <= 1'b1;
          cnt_oe_r   <= 1'b0;
          tx_ready_r <= 1'b1;
        end
      endcase
    end
  end

  cia_sp_sync u_cnt_sync (
    .clk   (clk),
    .res_n (res_n),
    .din   (cnt_in),
    .rise  (cnt_rise_s)
  );

  // Plain two-flop synchroniser for SP.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sp_meta_r <= 1'b1;
      sp_sync_r <= 1'b1;
    end else begin
      sp_meta_r <= sp_in;
      sp_sync_r <= sp_meta_r;
    end
  end

  // SP is delayed so it lines up with the registered (and optionally filtered) CNT edge.
`ifdef CIA_SP_PEER_FILTER_EN
  logic [2:0] sp_dly_r;

  // SP alignment delay matching the filtered CNT path.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sp_dly_r <= 3'b111;
    end else begin
      sp_dly_r <= {sp_dly_r[1:0], sp_sync_r};
    end
  end

  assign sp_al_s = sp_dly_r[2];
`else
  logic sp_dly_r;

  // SP alignment delay matching the unfiltered CNT path.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sp_dly_r <= 1'b1;
    end else begin
      sp_dly_r <= sp_sync_r;
    end
  end

  assign sp_al_s = sp_dly_r;
`endif

  // Our own CNT edges reach the edge detector a few cycles late, so the RX
  // hold-off extends past the end of cnt_oe by the longest pipeline depth.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      oe_hist_r <= 6'd0;
    end else begin
      oe_hist_r <= {oe_hist_r[4:0], cnt_oe_r};
    end
  end

  assign rx_block_s = cnt_oe_r | (|oe_hist_r);

  // RX shifter: one bit per accepted CNT edge, byte strobe on the 8th.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_cnt_r   <= 3'd0;
      rx_shift_r <= 7'd0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
    end else if (abort) begin
      rx_cnt_r   <= 3'd0;
      rx_valid_r <= 1'b0;
    end else if (handshake_s) begin
      rx_cnt_r   <= 3'd0;
      rx_shift_r <= 7'd0;
      rx_valid_r <= 1'b0;
    end else if (cnt_rise_s && !rx_block_s) begin
      rx_shift_r <= {rx_shift_r[5:0], sp_al_s};
      rx_cnt_r   <= rx_cnt_r + 3'd1;
      if (rx_cnt_r == 3'd7) begin
        rx_data_r  <= {rx_shift_r, sp_al_s};
        rx_valid_r <= 1'b1;
      end else begin
        rx_valid_r <= 1'b0;
      end
    end else begin
      rx_valid_r <= 1'b0;
    end
  end

  assign tx_ready = tx_ready_r;
  assign cnt_out  = cnt_out_r;
  assign sp_out   = sp_out_r;
  assign cnt_oe   = cnt_oe_r;
  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;

endmodule

// File: doc/cia_sp_peer.md
CIA_SP_PEER -- requirements
Module: cia_sp_peer

Interface
REQ-001 Parameter: HDIV_MIN, default 2, minimum half-period in clk cycles; lower hdiv values are clamped to this value.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 res_n  input  1  asynchronous active-low reset.
REQ-005 hdiv  input  8  CNT half-period in clk cycles, minus one; sampled at each transmission start.
REQ-006 tx_valid  input  1  byte offered for transmission.
REQ-007 tx_data  input  8  byte to transmit (cia::reg8_t).
REQ-008 tx_ready  output  1  high in IDLE; a transfer occurs when tx_valid and tx_ready are both high.
REQ-009 abort  input  1  synchronous cancel of TX and RX frames.
REQ-010 cnt_in, sp_in  input  1 each  CNT and SP pad levels from the CIA (asynchronous).
REQ-011 cnt_out, sp_out  output  1 each  CNT and SP drive levels toward the CIA.
REQ-012 cnt_oe  output  1  high while this block drives CNT and SP.
REQ-013 rx_valid  output  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-014 rx_data  output  8  last received byte; held until the next strobe.

Function
REQ-015 Bit order and polarity: MSB first, non-inverted, matching CIA SDR content.
REQ-016 TX states: IDLE, LOW, HIGH. On handshake in IDLE: latch tx_data and hdiv, assert cnt_oe, set bit index to 7, put sp_out to the bit, drive cnt_out=0, go to LOW.
REQ-017 LOW lasts max(hdiv,HDIV_MIN-1)+1 cycles, then cnt_out=1 and go to HIGH. The CIA samples SP on this rising CNT edge.
REQ-018 HIGH lasts the same count. Then:
- if bit index is not 0: decrement it, update sp_out to the next bit, set cnt_out=0, go to LOW;
- otherwise: go to IDLE with cnt_out=1, sp_out=1, cnt_oe=0.
REQ-019 One byte takes exactly 16 x (max(hdiv,HDIV_MIN-1)+1) cycles from the handshake to tx_ready rising. A handshake in that same cycle starts the next byte with no gap.
REQ-020 RX synchronises cnt_in and sp_in through 2 flops each. It detects rising edges of synchronised CNT and shifts synchronised SP into the LSB of an 8-bit shift register.
REQ-021 A 3-bit bit counter counts RX edges. On the 8th edge: rx_data gets the shifted byte, rx_valid pulses one cycle later than the edge, and the counter wraps to 0.
REQ-022 RX ignores CNT edges while cnt_oe=1. The RX counter and shift register clear when a TX handshake occurs.
REQ-023 abort: TX returns to IDLE with idle outputs on the next cycle, the RX counter clears, and rx_data is kept. abort wins over a simultaneous handshake or an 8th edge.

Reset
REQ-024 While res_n=0: TX state IDLE, cnt_out=1, sp_out=1, cnt_oe=0, tx_ready=0, rx_valid=0, rx_data=8'h00, counters 0, synchronisers 1.
REQ-025 tx_ready rises on the first clk edge after res_n deasserts. Reset mid-frame discards the frame with no rx_valid.

Configuration
REQ-026 Macro CIA_SP_PEER_FILTER_EN.
- Defined: synchronised CNT passes a 3-sample majority filter before edge detection, adding 2 cycles of RX latency and rejecting single-cycle glitches.
- Undefined: no filter, and a single-cycle CNT pulse counts as an edge.

Structure
REQ-027 Package cia holds the TX state enum type (sp_peer_state_t) and reuses reg8_t. No other new package.
REQ-028 Sub-module cia_sp_sync contains the synchroniser, the optional filter and the rising-edge detector, and is instantiated once for CNT. SP uses a plain 2-flop synchroniser.

Verification
REQ-029 Scenario 1: hdiv=3, send 8'hA5. The CIA model samples SP on CNT rising edges and gets 8'hA5. The frame lasts 64 cycles, and CNT has 8 low/high phases of 4 cycles each.
REQ-030 Scenario 2: hdiv=0. Half-periods are HDIV_MIN cycles; 8'h3C is sent in 32 cycles.
REQ-031 Scenario 3: drive 8 CNT rising edges with SP bits 1,0,0,1,1,1,0,1. rx_data=8'h9D and rx_valid is high for exactly 1 cycle.
REQ-032 Scenario 4: abort after 3 bits of TX 8'hFF. Idle outputs appear next cycle, and a new handshake with 8'h01 delivers 8'h01.
REQ-033 Scenario 5: res_n low during RX bit 5, then 8 new edges carrying 8'h42. rx_valid fires once with 8'h42.
REQ-034 Scenario 6 (with FILTER_EN): add 1-cycle CNT glitches between edges. rx_data is unchanged, with no extra counts. Without FILTER_EN the glitches are counted.
